// File: rtl/upc_loop_status_tracker.sv
// Activity tracker for an HLS block handshake and one pipelined loop FSM: iteration events plus invocation and cycle counters.
// Optional stall-cycle counter is built only when UPC_STALL_CNT_EN is defined.
module upc_loop_status_tracker #(
  parameter int STATE_W = 1,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic               ap_continue,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic [STATE_W-1:0] quit_state,
  input  logic               iter_start_block,
  input  logic               iter_end_block,
  input  logic               quit_block,
  input  logic               iter_start_enable,
  input  logic               iter_end_enable,
  input  logic               quit_enable,
  input  logic               loop_start,
  input  logic               loop_ready,
  input  logic               loop_done,
  input  logic               loop_continue,
  input  logic               quit_at_end,
  input  logic               finish,
  output logic               mod_busy,
  output logic               loop_busy,
  output logic [CNT_W-1:0]   mod_invocations,
  output logic [CNT_W-1:0]   mod_cycles,
  output logic [CNT_W-1:0]   loop_invocations,
  output logic [CNT_W-1:0]   iter_started,
  output logic [CNT_W-1:0]   iter_ended,
  output logic [CNT_W-1:0]   in_flight,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic               frozen
);

  typedef enum logic [1:0] {M_IDLE, M_RUN, M_WAIT} mod_state_e;
  typedef enum logic       {L_IDLE, L_ACT} loop_state_e;

  mod_state_e  mod_q, mod_d;
  loop_state_e loop_q, loop_d;
  logic [CNT_W-1:0] mod_inv_q, mod_inv_d;
  logic [CNT_W-1:0] mod_cyc_q, mod_cyc_d;
  logic [CNT_W-1:0] loop_inv_q, loop_inv_d;
  logic [CNT_W-1:0] started_q, started_d;
  logic [CNT_W-1:0] ended_q, ended_d;
  logic             frozen_q, frozen_d;
  logic             ev_start, ev_end, ev_quit;

  assign ev_start = (cur_state == iter_start_state) & ~iter_start_block & iter_start_enable;
  assign ev_end   = (cur_state == iter_end_state)   & ~iter_end_block   & iter_end_enable;
  assign ev_quit  = (cur_state == quit_state) & ~quit_block & quit_enable & quit_at_end;

  always_comb begin
    mod_d      = mod_q;
    loop_d     = loop_q;
    mod_inv_d  = mod_inv_q;
    mod_cyc_d  = mod_cyc_q;
    loop_inv_d = loop_inv_q;
    started_d  = started_q;
    ended_d    = ended_q;
    frozen_d   = frozen_q;
    // Once frozen, every register simply holds until reset.
    if (!frozen_q) begin
      frozen_d = finish;
      unique case (mod_q)
        M_IDLE:  if (ap_start) mod_d = M_RUN;
        M_RUN:   if (ap_done) mod_d = ap_continue ? (ap_start ? M_RUN : M_IDLE) : M_WAIT;
        M_WAIT:  if (ap_continue) mod_d = M_IDLE;
        default: mod_d = M_IDLE;
      endcase
      unique case (loop_q)
        L_IDLE:  if (loop_start) loop_d = L_ACT;
        L_ACT:   if ((loop_done & loop_continue) | ev_quit) loop_d = loop_start ? L_ACT : L_IDLE;
        default: loop_d = L_IDLE;
      endcase
      mod_inv_d  = mod_inv_q  + CNT_W'(ap_start & ap_ready);
      mod_cyc_d  = mod_cyc_q  + CNT_W'(mod_q != M_IDLE);
      loop_inv_d = loop_inv_q + CNT_W'(loop_start & loop_ready);
      started_d  = started_q  + CNT_W'(ev_start);
      ended_d    = ended_q    + CNT_W'(ev_end);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mod_q      <= M_IDLE;
      loop_q     <= L_IDLE;
      mod_inv_q  <= '0;
      mod_cyc_q  <= '0;
      loop_inv_q <= '0;
      started_q  <= '0;
      ended_q    <= '0;
      frozen_q   <= 1'b0;
    end else begin
      mod_q      <= mod_d;
      loop_q     <= loop_d;
      mod_inv_q  <= mod_inv_d;
      mod_cyc_q  <= mod_cyc_d;
      loop_inv_q <= loop_inv_d;
      started_q  <= started_d;
      ended_q    <= ended_d;
      frozen_q   <= frozen_d;
    end
  end

`ifdef UPC_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             stall_cond;

  assign stall_cond = (cur_state == iter_start_state) & iter_start_enable & iter_start_block
                      & (loop_q == L_ACT);

  always_comb begin
    stall_d = stall_q;
    if (!frozen_q) stall_d = stall_q + CNT_W'(stall_cond);
  end

  always_ff @(posedge clock) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

  assign mod_busy         = (mod_q != M_IDLE);
  assign loop_busy        = (loop_q == L_ACT);
  assign mod_invocations  = mod_inv_q;
  assign mod_cycles       = mod_cyc_q;
  assign loop_invocations = loop_inv_q;
  assign iter_started     = started_q;
  assign iter_ended       = ended_q;
  assign in_flight        = started_q - ended_q;
  assign frozen           = frozen_q;

endmodule

// File: tb/tb_upc_loop_status_tracker.sv
// Directed-vector bench for upc_loop_status_tracker; expected values are hand-computed per step.
module tb_upc_loop_status_tracker;
  logic        clock = 1'b0;
  logic        reset;
  logic        ap_start, ap_ready, ap_done, ap_continue;
  logic [0:0]  cur_state, iter_start_state, iter_end_state, quit_state;
  logic        iter_start_block, iter_end_block, quit_block;
  logic        iter_start_enable, iter_end_enable, quit_enable;
  logic        loop_start, loop_ready, loop_done, loop_continue, quit_at_end, finish;
  logic        mod_busy, loop_busy, frozen;
  logic [31:0] mod_invocations, mod_cycles, loop_invocations;
  logic [31:0] iter_started, iter_ended, in_flight, stall_cycles;

  int errors = 0;
  int checks = 0;
  int peak   = 0;
  int exp_stall;

  upc_loop_status_tracker #(.STATE_W(1), .CNT_W(32)) dut (
    .clock(clock), .reset(reset),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(iter_start_state),
    .iter_end_state(iter_end_state), .quit_state(quit_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
    .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
    .quit_enable(quit_enable),
    .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
    .loop_continue(loop_continue), .quit_at_end(quit_at_end), .finish(finish),
    .mod_busy(mod_busy), .loop_busy(loop_busy),
    .mod_invocations(mod_invocations), .mod_cycles(mod_cycles),
    .loop_invocations(loop_invocations), .iter_started(iter_started),
    .iter_ended(iter_ended), .in_flight(in_flight), .stall_cycles(stall_cycles),
    .frozen(frozen)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
    $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 1;
    cur_state = 0; iter_start_state = 0; iter_end_state = 0; quit_state = 0;
    iter_start_block = 0; iter_end_block = 0; quit_block = 0;
    iter_start_enable = 0; iter_end_enable = 0; quit_enable = 0;
    loop_start = 0; loop_ready = 0; loop_done = 0; loop_continue = 0;
    quit_at_end = 0; finish = 0;
  endtask

  initial begin
`ifdef UPC_STALL_CNT_EN
    exp_stall = 4;
`else
    exp_stall = 0;
`endif
    // Reset held 3 cycles with every input active
    clear_inputs();
    reset = 1;
    ap_start = 1; ap_ready = 1; ap_done = 1; iter_start_enable = 1; iter_end_enable = 1;
    quit_enable = 1; quit_at_end = 1; loop_start = 1; loop_ready = 1; finish = 1;
    repeat (3) tick();
    chk("rst_mod_busy", mod_busy, 0);
    chk("rst_loop_busy", loop_busy, 0);
    chk("rst_mod_inv", mod_invocations, 0);
    chk("rst_mod_cyc", mod_cycles, 0);
    chk("rst_loop_inv", loop_invocations, 0);
    chk("rst_started", iter_started, 0);
    chk("rst_ended", iter_ended, 0);
    chk("rst_in_flight", in_flight, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_frozen", frozen, 0);
    clear_inputs();
    reset = 0;
    tick();
    chk("idle_mod_busy", mod_busy, 0);

    // Single module invocation, 6 busy cycles, done with continue
    ap_start = 1; ap_ready = 1;
    tick();
    chk("m1_busy", mod_busy, 1);
    chk("m1_inv", mod_invocations, 1);
    ap_start = 0; ap_ready = 0;
    repeat (5) tick();
    chk("m1_cyc5", mod_cycles, 5);
    ap_done = 1;
    tick();
    chk("m1_cyc", mod_cycles, 6);
    chk("m1_busy_off", mod_busy, 0);
    tick();
    chk("m1_idle_done", mod_busy, 0);
    chk("m1_cyc_hold", mod_cycles, 6);
    ap_done = 0;

    // Done while continue low holds M_WAIT, wait cycles are counted
    ap_start = 1; ap_ready = 1;
    tick();
    ap_start = 0; ap_ready = 0;
    tick();
    chk("m2_cyc", mod_cycles, 7);
    ap_done = 1; ap_continue = 0;
    tick();
    chk("m2_wait_busy", mod_busy, 1);
    ap_done = 0;
    tick();
    chk("m2_wait_busy2", mod_busy, 1);
    chk("m2_wait_cyc", mod_cycles, 9);
    ap_continue = 1;
    tick();
    chk("m2_exit_busy", mod_busy, 0);
    chk("m2_exit_cyc", mod_cycles, 10);
    chk("m2_inv", mod_invocations, 2);

    // Back-to-back: done&continue with ap_start keeps M_RUN
    ap_start = 1; ap_ready = 1;
    tick();
    ap_done = 1;
    tick();
    chk("m3_b2b_busy", mod_busy, 1);
    chk("m3_b2b_inv", mod_invocations, 4);
    ap_start = 0; ap_ready = 0;
    tick();
    chk("m3_exit_busy", mod_busy, 0);
    chk("m3_cyc", mod_cycles, 12);
    ap_done = 0;

    // Loop of 8 iterations, II=1; last stage sees iteration k three cycles after it starts
    loop_start = 1; loop_ready = 1;
    tick();
    chk("l1_busy", loop_busy, 1);
    chk("l1_inv", loop_invocations, 1);
    loop_start = 0; loop_ready = 0;
    for (int c = 0; c < 11; c++) begin
      iter_start_enable = (c < 8);
      iter_end_enable   = (c >= 3);
      tick();
      chk($sformatf("l1_start_c%0d", c), iter_started, (c < 7) ? c + 1 : 8);
      chk($sformatf("l1_end_c%0d", c), iter_ended, (c >= 3) ? c - 2 : 0);
      chk($sformatf("l1_infl_c%0d", c), in_flight,
          ((c < 7) ? c + 1 : 8) - ((c >= 3) ? c - 2 : 0));
      if (int'(in_flight) > peak) peak = int'(in_flight);
    end
    iter_start_enable = 0; iter_end_enable = 0;
    chk("l1_peak", peak, 3);
    chk("l1_stall", stall_cycles, 0);
    loop_done = 1; loop_continue = 1;
    tick();
    chk("l1_exit_busy", loop_busy, 0);
    loop_done = 0; loop_continue = 0;

    // Quit path: needs quit_at_end and no quit_block
    loop_start = 1; loop_ready = 1;
    tick();
    loop_start = 0; loop_ready = 0;
    quit_enable = 1; quit_at_end = 0;
    tick();
    chk("q_no_at_end", loop_busy, 1);
    quit_at_end = 1; quit_block = 1;
    tick();
    chk("q_blocked", loop_busy, 1);
    quit_block = 0;
    tick();
    chk("q_exit", loop_busy, 0);
    chk("q_loop_inv", loop_invocations, 2);
    quit_enable = 0; quit_at_end = 0;

    // Start stall for 4 cycles mid-stream
    loop_start = 1; loop_ready = 1;
    tick();
    loop_start = 0; loop_ready = 0;
    iter_start_enable = 1;
    repeat (2) tick();
    chk("s_pre", iter_started, 10);
    iter_start_block = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("s_hold_%0d", c), iter_started, 10);
    end
    iter_start_block = 0;
    repeat (2) tick();
    chk("s_post", iter_started, 12);
    chk("s_stall", stall_cycles, exp_stall);
    iter_start_enable = 0; iter_end_enable = 1;
    repeat (4) tick();
    chk("s_ended", iter_ended, 12);
    chk("s_in_flight", in_flight, 0);
    iter_end_enable = 0;
    loop_done = 1; loop_continue = 1;
    tick();
    loop_done = 0; loop_continue = 0;
    iter_start_enable = 1; iter_start_block = 1;
    tick();
    chk("s_idle_stall", stall_cycles, exp_stall);
    iter_start_block = 0; cur_state = 1;
    tick();
    chk("s_state_mis", iter_started, 12);
    cur_state = 0; iter_start_enable = 0;

    // Finish mid-loop: event in the finish cycle counts, then everything holds
    loop_start = 1; loop_ready = 1;
    tick();
    loop_start = 0; loop_ready = 0;
    iter_start_enable = 1; finish = 1;
    tick();
    chk("f_frozen", frozen, 1);
    chk("f_started", iter_started, 13);
    finish = 0; iter_end_enable = 1; ap_start = 1; ap_ready = 1;
    loop_done = 1; loop_continue = 1; loop_start = 1; loop_ready = 1;
    repeat (3) tick();
    chk("f_started_h", iter_started, 13);
    chk("f_ended_h", iter_ended, 12);
    chk("f_infl_h", in_flight, 1);
    chk("f_mod_inv_h", mod_invocations, 4);
    chk("f_mod_cyc_h", mod_cycles, 12);
    chk("f_mod_busy_h", mod_busy, 0);
    chk("f_loop_busy_h", loop_busy, 1);
    chk("f_loop_inv_h", loop_invocations, 4);
    chk("f_frozen_h", frozen, 1);
    reset = 1;
    tick();
    clear_inputs();
    reset = 0;
    tick();
    chk("r_frozen", frozen, 0);
    chk("r_started", iter_started, 0);
    chk("r_ended", iter_ended, 0);
    chk("r_mod_inv", mod_invocations, 0);
    chk("r_mod_cyc", mod_cycles, 0);
    chk("r_loop_inv", loop_invocations, 0);
    chk("r_loop_busy", loop_busy, 0);
    chk("r_stall", stall_cycles, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
